ucaspian_synapse: RTL and testbench

- Synapse stage that drives the dendrite's synapse-side input (dend_addr / dend_charge / dend_vld / dend_rdy).
- Accepts fire requests, each a contiguous synapse range owned by one firing neuron.
- Reads each synapse entry (target dendrite address, signed weight) from a local synapse RAM and streams one charge packet per synapse to the dendrite under valid/ready flow control.
- Also owns synapse configuration writes and the clear-config sweep.

---
 rtl/ucaspian_pkg.sv | 19 +
 rtl/ucaspian_synapse_if.sv | 32 +++
 rtl/ucaspian_dp_ram.sv | 22 ++
 rtl/ucaspian_skid_fifo.sv | 58 +++++
 rtl/ucaspian_synapse.sv | 177 +++++++++++++++++
 tb/tb_ucaspian_synapse.sv | 308 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ucaspian_pkg.sv
// ucaspian shared types: synapse RAM entry, synapse FSM state, fire count width.
// No ports; imported with import ucaspian_pkg::*.
package ucaspian_pkg;

  localparam int SYN_FIRE_CNT_W = 9;

  typedef struct packed {
    logic        [7:0] target;
    logic signed [7:0] weight;
  } syn_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_CLEAR
  } syn_state_t;

endpackage

// File: rtl/ucaspian_synapse_if.sv
// Synapse stage handshakes: fire request in, dendrite charge packet out.
// master: requester / dendrite side; slave: the synapse stage.
interface ucaspian_synapse_if #(
  parameter int SYN_AW = 12
);
  import ucaspian_pkg::*;

  logic [SYN_AW-1:0]         fire_start;
  logic [SYN_FIRE_CNT_W-1:0] fire_count;
  logic                      fire_vld;
  logic                      fire_rdy;

  logic [7:0]                dend_addr;
  logic [8:0]                dend_charge;
  logic                      dend_vld;
  logic                      dend_rdy;

  modport master (
    output fire_start, fire_count, fire_vld,
    input  fire_rdy,
    input  dend_addr, dend_charge, dend_vld,
    output dend_rdy
  );

  modport slave (
    input  fire_start, fire_count, fire_vld,
    output fire_rdy,
    output dend_addr, dend_charge, dend_vld,
    input  dend_rdy
  );

endinterface

// File: rtl/ucaspian_dp_ram.sv
// Simple dual-port RAM, 1-cycle registered read, read-before-write.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module ucaspian_dp_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ucaspian_skid_fifo.sv
// Register-based valid/ready FIFO; head entry drives the output directly.
// Ports: clk, reset, flush, in_* push side, out_* pop side, count occupancy.
module ucaspian_skid_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [W-1:0]  in_data,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_rdy   = cnt_q != CW'(DEPTH);
  assign out_vld  = cnt_q != '0;
  assign out_data = mem_q[rd_q];
  assign count    = cnt_q;
  assign push     = in_vld && in_rdy;
  assign pop      = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= inc(wr_q);
      end
      if (pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/ucaspian_synapse.sv
// Synapse stage: expands fire ranges into dendrite charge packets, owns config/clear.
// Ports: clk, reset, enable, clear_config/clear_done, next_step/step_done,
//   cfg_addr/cfg_data/cfg_wr, bus (fire_* in, dend_* out).
// Build option: UCASPIAN_SYN_SKIP_ZERO_EN drops zero-weight packets.
module ucaspian_synapse
  import ucaspian_pkg::*;
#(
  parameter int SYN_AW     = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_config,
  output logic              clear_done,
  input  logic              next_step,
  output logic              step_done,
  input  logic [SYN_AW-1:0] cfg_addr,
  input  logic [15:0]       cfg_data,
  input  logic              cfg_wr,
  ucaspian_synapse_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  syn_state_t                state_q, state_d;
  logic [SYN_AW-1:0]         cur_q, cur_d;
  logic [SYN_AW-1:0]         clr_q, clr_d;
  logic [SYN_FIRE_CNT_W-1:0] rem_q, rem_d;
  logic                      infl_q;
  logic                      step_done_q, step_done_d;
  logic                      clear_done_q, clear_done_d;

  logic              fire_rdy, fire_hs;
  logic              issue, credit, pop, push, keep;
  logic              sweeping, ram_we;
  logic [SYN_AW-1:0] ram_waddr;
  logic [15:0]       ram_wdata, ram_rdata;
  syn_entry_t        rd_ent, head;
  logic [15:0]       fifo_out;
  logic              fifo_vld, fifo_rdy_unused;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       used;

  assign fire_rdy = !reset && (state_q == S_IDLE)
                 && enable && !clear_config;
  assign fire_hs  = bus.fire_vld && fire_rdy;
  assign pop      = fifo_vld && bus.dend_rdy;

  // A same-cycle pop frees a slot, so it counts toward
  // credit; that is what lets depth 2 run at 1/cycle.
  assign used   = {1'b0, fifo_cnt} + (CW+1)'(infl_q)
                - (CW+1)'(pop);
  assign credit = used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    rem_d        = rem_q;
    clr_d        = '0;
    issue        = 1'b0;
    clear_done_d = 1'b0;
    if (clear_config) begin
      if (state_q == S_CLEAR) begin
        clr_d = clr_q + SYN_AW'(1);
        if (clr_q == '1) begin
          clear_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end else begin
        state_d = S_CLEAR;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fire_hs) begin
            cur_d = bus.fire_start;
            rem_d = bus.fire_count;
            if (bus.fire_count != '0) state_d = S_READ;
          end
        end
        S_READ: begin
          if (credit) begin
            issue = 1'b1;
            cur_d = cur_q + SYN_AW'(1);
            rem_d = rem_q - SYN_FIRE_CNT_W'(1);
            if (rem_q == SYN_FIRE_CNT_W'(1)) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!infl_q) state_d = S_IDLE;
        end
        S_CLEAR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign step_done_d = (state_q == S_IDLE) && (fifo_cnt == '0)
                    && !infl_q && !bus.fire_vld
                    && !next_step && !clear_config;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      rem_q        <= '0;
      clr_q        <= '0;
      infl_q       <= 1'b0;
      step_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      rem_q        <= rem_d;
      clr_q        <= clr_d;
      infl_q       <= issue;
      step_done_q  <= step_done_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign sweeping  = (state_q == S_CLEAR) && clear_config;
  assign ram_we    = sweeping || (cfg_wr && state_q != S_CLEAR);
  assign ram_waddr = sweeping ? clr_q : cfg_addr;
  assign ram_wdata = sweeping ? 16'h0 : cfg_data;

  ucaspian_dp_ram #(
    .AW (SYN_AW),
    .DW (16)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cur_q),
    .rdata (ram_rdata)
  );

  assign rd_ent = syn_entry_t'(ram_rdata);

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign keep = rd_ent.weight != 8'sd0;
`else
  assign keep = 1'b1;
`endif

  // A return landing while clear is asserted belongs to
  // the aborted range and is discarded.
  assign push = infl_q && !clear_config && keep;

  ucaspian_skid_fifo #(
    .W     (16),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear_config),
    .in_data  (ram_rdata),
    .in_vld   (push),
    .in_rdy   (fifo_rdy_unused),
    .out_data (fifo_out),
    .out_vld  (fifo_vld),
    .out_rdy  (bus.dend_rdy),
    .count    (fifo_cnt)
  );

  assign head            = syn_entry_t'(fifo_out);
  assign bus.fire_rdy    = fire_rdy;
  assign bus.dend_vld    = fifo_vld;
  assign bus.dend_addr   = head.target;
  assign bus.dend_charge = {head.weight[7], head.weight};
  assign step_done       = step_done_q;
  assign clear_done      = clear_done_q;

endmodule

// File: tb/tb_ucaspian_synapse.sv
// Scoreboard bench for ucaspian_synapse: RAM image model, queued packets,
// negedge monitor checking order, values and stall stability.
module tb_ucaspian_synapse;
  import ucaspian_pkg::*;

  localparam int AW = 12;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          clear_config = 1'b0;
  logic          next_step = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_data = '0;
  logic          clear_done, step_done;

  ucaspian_synapse_if #(.SYN_AW(AW)) bus();

  ucaspian_synapse #(
    .SYN_AW     (AW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear_config (clear_config),
    .clear_done   (clear_done),
    .next_step    (next_step),
    .step_done    (step_done),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_wr       (cfg_wr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int npop = 0;
  int hs_cyc = 0;
  bit rdy_rand = 1'b0;

  logic [15:0] ram_m [N];
  logic [16:0] exp_q [$];
  int          acc_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] expv);
    nchk++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) bus.dend_rdy = 1'($urandom_range(0, 1));
  end

  bit          prev_stall = 1'b0;
  logic [16:0] prev_pkt = '0;
  logic [16:0] pk;

  always @(negedge clk) begin
    pk = {bus.dend_addr, bus.dend_charge};
    if (!reset) begin
      if (prev_stall) begin
        chk("stall_vld", 32'(bus.dend_vld), 1);
        chk("stall_data", 32'(pk), 32'(prev_pkt));
      end
      if (bus.dend_vld && bus.dend_rdy) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_packet: got %0h expected none", pk);
        end else begin
          chk("packet", 32'(pk), 32'(exp_q.pop_front()));
        end
        acc_cyc.push_back(cyc);
        npop++;
      end
    end
    prev_stall = !reset && !clear_config && bus.dend_vld && !bus.dend_rdy;
    prev_pkt   = pk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fire(input logic [AW-1:0] s, input int n);
    logic [15:0]       e;
    logic signed [8:0] ch;
    for (int i = 0; i < n; i++) begin
      e  = ram_m[(int'(s) + i) % N];
      ch = $signed(e[7:0]);
`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
      if (e[7:0] != 8'h00) exp_q.push_back({e[15:8], ch});
`else
      exp_q.push_back({e[15:8], ch});
`endif
    end
  endtask

  task automatic do_fire(input logic [AW-1:0] s, input int n);
    bit ok;
    ok = 1'b0;
    bus.fire_start = s;
    bus.fire_count = 9'(n);
    bus.fire_vld   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.fire_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fire_accept", 32'(ok), 1);
    if (ok) model_fire(s, n);
    tick();
    hs_cyc = cyc;
    bus.fire_vld = 1'b0;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [15:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
    ram_m[a] = d;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (step_done && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 1);
    tick();
  endtask

  task automatic do_clear();
    int  c0, t;
    bit  ok;
    ok = 1'b0;
    t  = 0;
    clear_config = 1'b1;
    c0 = cyc;
    tick();
    chk("clear_drop_vld", 32'(bus.dend_vld), 0);
    exp_q.delete();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (clear_done) begin
        ok = 1'b1;
        t  = cyc - c0;
        break;
      end
    end
    chk("clear_done_seen", 32'(ok), 1);
    chk("clear_latency", 32'(t >= 4096 && t <= 4098), 1);
    tick();
    chk("clear_done_pulse", 32'(clear_done), 0);
    clear_config = 1'b0;
    for (int i = 0; i < N; i++) ram_m[i] = 16'h0;
    tick();
  endtask

  initial begin
    int p0, nexp;
    bus.fire_start = '0;
    bus.fire_count = '0;
    bus.fire_vld   = 1'b0;
    bus.dend_rdy   = 1'b1;

    repeat (3) tick();
    chk("rst_fire_rdy", 32'(bus.fire_rdy), 0);
    chk("rst_dend_vld", 32'(bus.dend_vld), 0);
    chk("rst_dend_addr", 32'(bus.dend_addr), 0);
    chk("rst_dend_charge", 32'(bus.dend_charge), 0);
    chk("rst_step_done", 32'(step_done), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_fire_rdy", 32'(bus.fire_rdy), 1);

    do_clear();

    cfg_write(12'h010, 16'h057F);
    cfg_write(12'h011, 16'h0680);
    for (int i = 0; i < 4; i++)
      cfg_write(12'(12'hFFE + i), {8'(8'hC0 + i), 8'($urandom_range(1, 255))});
    for (int i = 0; i < 256; i++)
      cfg_write(12'(12'h300 + i),
                {8'($urandom), (i % 37 == 0) ? 8'h00 : 8'($urandom)});

    acc_cyc.delete();
    do_fire(12'h010, 2);
    wait_idle("idle_basic", 100);
    chk("basic_count", 32'(acc_cyc.size()), 2);
    if (acc_cyc.size() >= 2) begin
      chk("lat_first", 32'(acc_cyc[0] - hs_cyc), 2);
      chk("lat_second", 32'(acc_cyc[1] - acc_cyc[0]), 1);
    end

    tick();
    next_step = 1'b1;
    tick();
    next_step = 1'b0;
    chk("next_step_clears", 32'(step_done), 0);
    tick();
    chk("step_done_returns", 32'(step_done), 1);

    rdy_rand = 1'b1;
    p0 = npop;
    do_fire(12'hFFE, 4);
    wait_idle("idle_wrap", 200);
    chk("wrap_count", 32'(npop - p0), 4);

    p0 = npop;
    do_fire(12'h300, 256);
    nexp = exp_q.size();
    enable = 1'b0;
    wait_idle("idle_256", 3000);
    enable = 1'b1;
    chk("count_256", 32'(npop - p0), 32'(nexp));

    rdy_rand = 1'b0;
    bus.dend_rdy = 1'b1;
    do_fire(12'h123, 0);
    chk("zero_fire_rdy", 32'(bus.fire_rdy), 1);
    repeat (5) tick();
    chk("zero_no_vld", 32'(bus.dend_vld), 0);
    chk("zero_step_done", 32'(step_done), 1);

    enable = 1'b0;
    bus.fire_start = 12'h010;
    bus.fire_count = 9'd2;
    bus.fire_vld   = 1'b1;
    repeat (3) tick();
    chk("enable_blocks", 32'(bus.fire_rdy), 0);
    chk("enable_no_vld", 32'(bus.dend_vld), 0);
    bus.fire_vld = 1'b0;
    enable = 1'b1;
    tick();

    rdy_rand = 1'b1;
    do_fire(12'h300, 256);
    repeat (20) tick();
    do_clear();
    rdy_rand = 1'b0;
    bus.dend_rdy = 1'b1;
    p0 = npop;
    do_fire(12'(12'h300 + $urandom_range(0, 255)), 5);
    nexp = exp_q.size();
    wait_idle("idle_after_clear", 100);
    chk("after_clear_count", 32'(npop - p0), 32'(nexp));

    for (int i = 0; i < 8; i++)
      cfg_write(12'(12'h100 + i), {8'(8'hA0 + i), 8'(8'h11 + i)});
    bus.dend_rdy = 1'b0;
    do_fire(12'h100, 8);
    repeat (6) tick();
    chk("full_vld", 32'(bus.dend_vld), 1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_rst_vld", 32'(bus.dend_vld), 0);
    chk("mid_rst_addr", 32'(bus.dend_addr), 0);
    chk("mid_rst_charge", 32'(bus.dend_charge), 0);
    chk("mid_rst_step", 32'(step_done), 0);
    chk("mid_rst_fire_rdy", 32'(bus.fire_rdy), 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_fire_rdy_up", 32'(bus.fire_rdy), 1);

    bus.dend_rdy = 1'b1;
    p0 = npop;
    do_fire(12'h100, 8);
    wait_idle("idle_post_reset", 100);
    chk("post_reset_count", 32'(npop - p0), 8);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
